// File: rtl/teller_dispatcher.sv
// Dispatches waiting customers to up to three tellers using round-robin selection,
// with a per-teller service timer and early-completion pulses.
module teller_dispatcher #(
  parameter int SERVICE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] tCount,
  input  logic [2:0] pCount,
  input  logic       emptyFlag,
  input  logic [2:0] done,
  output logic       front,
  output logic [2:0] busy,
  output logic [1:0] assign_id,
  output logic       assign_valid,
  output logic [7:0] served_count,
  output logic [1:0] dbgState
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DISPATCH = 2'd1;
  localparam logic [1:0] SETTLE   = 2'd2;

  // Handshake: front/assign_valid are a single-cycle strobe with no ready;
  // the queue manager must consume the head customer in that same cycle.

  logic [1:0] state;
  logic [1:0] lastId;
  logic [1:0] effCount;
  logic [2:0] openMask;
  logic [2:0] eligible;
  logic [1:0] startId;
  logic [1:0] pickId;
  logic       pickFound;

  assign effCount = (tCount == 2'd0) ? 2'd1 : tCount;
  assign startId  = (lastId == 2'd2) ? 2'd0 : lastId + 2'd1;

  always_comb begin
    openMask = 3'b000;
    for (int i = 0; i < 3; i++) begin
      openMask[i] = (2'(i) < effCount);
    end
  end

  // Registered busy only, so a teller freed at an edge is eligible one cycle later.
  assign eligible = openMask & ~busy;

  always_comb begin
    int c;
    pickFound = 1'b0;
    pickId    = 2'd0;
    c         = 0;
    for (int k = 0; k < 3; k++) begin
      c = int'(startId) + k;
      if (c > 2) c = c - 3;
      if (!pickFound && eligible[2'(c)]) begin
        pickFound = 1'b1;
        pickId    = 2'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      assign_id <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pCount != 3'd0 && !emptyFlag && pickFound) begin
            state     <= DISPATCH;
            assign_id <= pickId;
          end
        end
        DISPATCH: state <= SETTLE;
        SETTLE:   state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastId       <= 2'd2;
      served_count <= 8'd0;
    end else if (state == DISPATCH) begin
      lastId <= assign_id;
      if (served_count != 8'hFF) served_count <= served_count + 8'd1;
    end
  end

  assign front        = (state == DISPATCH);
  assign assign_valid = (state == DISPATCH);
  assign dbgState     = state;

  for (genvar g = 0; g < 3; g++) begin : gTeller
    logic [3:0] timer;
    logic       busyBit;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        timer   <= 4'd0;
        busyBit <= 1'b0;
      end else if (state == DISPATCH && assign_id == 2'(g)) begin
        timer   <= 4'(SERVICE_CYCLES);
        busyBit <= 1'b1;
      end else if (busyBit) begin
        if (done[g]) begin
          timer   <= 4'd0;
          busyBit <= 1'b0;
        end else begin
          timer <= timer - 4'd1;
          if (timer == 4'd1) busyBit <= 1'b0;
        end
      end
    end

    assign busy[g] = busyBit;
  end

endmodule

// File: tb/tb_teller_dispatcher.sv
// Directed and randomized checks of teller_dispatcher against a timeline model
// that tracks each teller as a busy interval [busyFrom, freeAt).
module tb_teller_dispatcher;

  localparam int SC = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] tCount = 2'd0;
  logic [2:0] pCount = 3'd0;
  logic       emptyFlag = 1'b0;
  logic [2:0] done = 3'd0;
  logic       front;
  logic [2:0] busy;
  logic [1:0] assign_id;
  logic       assign_valid;
  logic [7:0] served_count;
  logic [1:0] dbgState;

  teller_dispatcher #(.SERVICE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .tCount(tCount), .pCount(pCount),
    .emptyFlag(emptyFlag), .done(done), .front(front), .busy(busy),
    .assign_id(assign_id), .assign_valid(assign_valid),
    .served_count(served_count), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: cycle index since reset release, busy intervals per teller.
  int t;
  int busyFrom [3];
  int freeAt [3];
  int lastFrontM;
  int lastIdM;
  int servedM;
  int assignM;
  int curId;
  bit frontNow;
  int nDisp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < 3; i++) begin
      busyFrom[i] = 0;
      freeAt[i] = 0;
    end
    lastFrontM = -3;
    lastIdM = 2;
    servedM = 0;
    assignM = 0;
    curId = 0;
    frontNow = 1'b0;
  endtask

  function automatic logic [2:0] model_busy(input int cyc);
    logic [2:0] b;
    for (int i = 0; i < 3; i++) b[i] = (cyc >= busyFrom[i]) && (cyc < freeAt[i]);
    return b;
  endfunction

  // Assert reset mid-cycle, check reset values asynchronously, release after one edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_front", 32'(front), 32'd0);
    check("rst_valid", 32'(assign_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_served", 32'(served_count), 32'd0);
    check("rst_assign_id", 32'(assign_id), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic [1:0] tc, input logic [2:0] pc, input logic ef, input logic [2:0] dn);
    logic [2:0] bz;
    int effT;
    bit nextFront;
    int pick;
    tCount = tc;
    pCount = pc;
    emptyFlag = ef;
    done = dn;
    effT = (tc == 2'd0) ? 1 : int'(tc);
    bz = model_busy(t);
    if (frontNow) begin
      busyFrom[curId] = t + 1;
      freeAt[curId] = t + 1 + SC;
      lastIdM = curId;
      if (servedM < 255) servedM++;
      lastFrontM = t;
      nDisp++;
    end
    for (int i = 0; i < 3; i++) if (dn[i] && bz[i]) freeAt[i] = t + 1;
    nextFront = 1'b0;
    pick = 0;
    if ((t + 1 >= lastFrontM + 3) && pc != 3'd0 && !ef) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (lastIdM + 1 + k) % 3;
        if (!nextFront && idx < effT && !bz[idx]) begin
          nextFront = 1'b1;
          pick = idx;
        end
      end
    end
    @(posedge clk);
    #1;
    t++;
    frontNow = nextFront;
    if (nextFront) begin
      curId = pick;
      assignM = pick;
    end
    check("front", 32'(front), 32'(frontNow));
    check("assign_valid", 32'(assign_valid), 32'(frontNow));
    check("assign_id", 32'(assign_id), 32'(assignM));
    check("busy", 32'(busy), 32'(model_busy(t)));
    check("served_count", 32'(served_count), 32'(servedM));
  endtask

  initial begin
    int fq[$];
    int hits;
    bit ok;
    nDisp = 0;
    model_reset();
    do_reset();

    // Three tellers open, steady queue: fronts at 1,4,7 to tellers 0,1,2.
    for (int i = 0; i < 8; i++) begin
      step(2'd3, 3'd5, 1'b0, 3'd0);
      if (t == 1 || t == 4 || t == 7) begin
        check("req030_front", 32'(front), 32'd1);
        check("req030_id", 32'(assign_id), 32'((t - 1) / 3));
      end
    end
    check("req030_busy", 32'(busy), 32'd7);
    check("req030_served", 32'(served_count), 32'd3);

    // Single teller: second dispatch waits for the service timer.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(2'd1, 3'd2, 1'b0, 3'd0);
      if (front) begin
        fq.push_back(t);
        check("req031_id", 32'(assign_id), 32'd0);
      end
    end
    check("req031_first", 32'(fq.size() > 0 ? fq[0] : -1), 32'd1);
    check("req031_second", 32'(fq.size() > 1 ? fq[1] : -1), 32'd11);

    // Early done on teller 1 with all tellers busy.
    do_reset();
    for (int i = 0; i < 8; i++) step(2'd3, 3'd5, 1'b0, 3'd0);
    step(2'd3, 3'd5, 1'b0, 3'b010);
    check("req032_busy_after_done", 32'(busy), 32'b101);
    step(2'd3, 3'd5, 1'b0, 3'd0);
    check("req032_front", 32'(front), 32'd1);
    check("req032_id", 32'(assign_id), 32'd1);

    // Close tellers 1,2 while busy: they finish, then only teller 0 gets work.
    for (int i = 0; i < 40; i++) begin
      step(2'd1, 3'd5, 1'b0, 3'd0);
      if (front && i > 2) check("req033_id", 32'(assign_id), 32'd0);
    end
    check("req033_busy12", 32'(busy[2:1]), 32'd0);

    // Empty flag blocks dispatch regardless of pCount.
    hits = int'(served_count);
    for (int i = 0; i < 20; i++) step(2'd3, 3'd3, 1'b1, 3'd0);
    check("req034_served", 32'(served_count), 32'(hits));

    // Randomized phase.
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0);
    end

    // Reset during DISPATCH.
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(2'd3, 3'd5, 1'b0, 3'd0);
      if (frontNow) ok = 1'b1;
    end
    check("req035_reach_dispatch", 32'(ok), 32'd1);
    do_reset();

    // Saturation after 256 dispatches.
    nDisp = 0;
    for (int i = 0; i < 2000 && nDisp < 256; i++) step(2'd3, 3'd5, 1'b0, 3'b111);
    for (int i = 0; i < 4; i++) step(2'd3, 3'd5, 1'b0, 3'b111);
    check("req035_dispatches", 32'(nDisp >= 256), 32'd1);
    check("req035_saturate", 32'(served_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
